// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
//
// Purpose:
//   Receive-side checker for the 8-bit PRBS byte stream produced by the
//   matching generator.  The checker hunts for a nonzero seed byte, confirms
//   alignment over LOCK_CNT consecutive predicted bytes, and then flywheels
//   the LFSR while LOCKED, counting every byte that disagrees with the
//   prediction.  LOSS_CNT consecutive disagreements drop lock and restart
//   the hunt.  The error count saturates at 99 so it always fits two
//   decimal digits on the 7-segment display.
//
// Parameters:
//   LOCK_CNT  consecutive matching bytes needed to declare lock (1..15)
//   LOSS_CNT  consecutive mismatching bytes in LOCKED that drop lock (1..15)
//
// Ports:
//   clk         in   1  single clock, all state changes on the rising edge
//   rst         in   1  asynchronous reset, active low
//   data_in     in   8  received PRBS byte
//   data_valid  in   1  data_in is sampled on an edge where this is 1
//   clr         in   1  synchronous clear of the error count and digits
//   locked      out  1  checker is in LOCKED
//   err_pulse   out  1  one-cycle pulse per mismatched byte while LOCKED
//   err_cnt     out  7  binary error count, saturating at 99
//   dig_tens    out  4  BCD tens digit of err_cnt
//   dig_ones    out  4  BCD ones digit of err_cnt
//
// Configuration:
//   PRBS_CHK_BCD_EN  when defined, dig_tens/dig_ones run as a BCD counter
//                    that tracks err_cnt; when undefined both digits are
//                    tied to zero and no BCD logic exists.
// ---------------------------------------------------------------------------
module prbs_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       clr,
    output logic       locked,
    output logic       err_pulse,
    output logic [6:0] err_cnt,
    output logic [3:0] dig_tens,
    output logic [3:0] dig_ones
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TH = 4'(LOSS_CNT);
    localparam logic [6:0] ERR_MAX = 7'd99;

    state_t     state;
    logic [7:0] expected;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;
    logic       byte_match;
    logic       lock_err;
    logic       err_saturated;

    // Same polynomial as the generator: taps at bits 7, 5, 4 and 3 feed the
    // new LSB while the register shifts left.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Byte comparison and the error event are shared by the FSM (for the
    // miss counter and err_pulse) and by both counters below, so a counted
    // error and its pulse can never disagree.
    always_comb begin
        byte_match    = (data_in == expected);
        lock_err      = data_valid && (state == LOCKED) && !byte_match;
        err_saturated = (err_cnt == ERR_MAX);
    end

    // Main checker FSM.  State, the predicted byte, both run-length counters
    // and the locked/err_pulse outputs all live in this one block so that
    // locked changes on exactly the same edge as the state.
    //
    // HUNT waits for a nonzero seed (0x00 would lock the LFSR at zero and is
    // therefore never a valid seed).  SYNC keeps reseeding from the incoming
    // byte on any mismatch until LOCK_CNT predictions in a row come true.
    // LOCKED never reseeds: the LFSR freewheels on every valid byte so a
    // single corrupted byte costs exactly one error and alignment survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            expected  <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= lock_err;
            if (data_valid) begin
                case (state)
                    HUNT: begin
                        if (data_in != 8'h00) begin
                            expected  <= lfsr_next(data_in);
                            match_cnt <= 4'd0;
                            state     <= SYNC;
                        end
                    end

                    SYNC: begin
                        if (byte_match) begin
                            expected  <= lfsr_next(expected);
                            match_cnt <= match_cnt + 4'd1;
                            if ((match_cnt + 4'd1) == LOCK_TH) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= 4'd0;
                            end
                        end else if (data_in != 8'h00) begin
                            expected  <= lfsr_next(data_in);
                            match_cnt <= 4'd0;
                        end else begin
                            match_cnt <= 4'd0;
                            state     <= HUNT;
                        end
                    end

                    LOCKED: begin
                        expected <= lfsr_next(expected);
                        if (byte_match) begin
                            miss_cnt <= 4'd0;
                        end else if ((miss_cnt + 4'd1) == LOSS_TH) begin
                            miss_cnt <= 4'd0;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else begin
                            miss_cnt <= miss_cnt + 4'd1;
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Binary error counter.  clr takes priority over a simultaneous error so
    // the operator always sees a clean zero after clearing; the pulse for
    // that error still goes out from the FSM block.  Losing lock does not
    // touch the count, so errors that caused the loss remain visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= 7'd0;
        end else if (clr) begin
            err_cnt <= 7'd0;
        end else if (lock_err && !err_saturated) begin
            err_cnt <= err_cnt + 7'd1;
        end
    end

`ifdef PRBS_CHK_BCD_EN
    // Decimal shadow of err_cnt for the display.  It is counted directly in
    // BCD rather than converted from binary, which avoids a divider; it
    // follows exactly the same clear/increment/saturate rules, so 99 in
    // binary coincides with 9/9 here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_tens <= 4'd0;
            dig_ones <= 4'd0;
        end else if (clr) begin
            dig_tens <= 4'd0;
            dig_ones <= 4'd0;
        end else if (lock_err && !((dig_tens == 4'd9) && (dig_ones == 4'd9))) begin
            if (dig_ones == 4'd9) begin
                dig_ones <= 4'd0;
                dig_tens <= dig_tens + 4'd1;
            end else begin
                dig_ones <= dig_ones + 4'd1;
            end
        end
    end
`else
    // Display digits not built in this configuration.
    assign dig_tens = 4'd0;
    assign dig_ones = 4'd0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
//
// Purpose:
//   Self-checking bench for prbs_checker.  A byte-level reference model
//   (lock/track flags, run lengths, predicted byte and an error tally) is
//   stepped alongside the DUT; after every clock all outputs are compared
//   with the model.  A local PRBS generator supplies the received stream,
//   into which corrupted bytes, zero bytes, idle cycles, clears, stream
//   jumps and a mid-cycle reset are injected.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_prbs_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       clr;
    logic       locked;
    logic       err_pulse;
    logic [6:0] err_cnt;
    logic [3:0] dig_tens;
    logic [3:0] dig_ones;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    bit         m_locked;
    bit         m_tracking;
    logic [7:0] m_exp;
    int         m_match;
    int         m_miss;
    int         m_cnt;
    bit         m_pulse;

    // Local PRBS generator; gen is the byte the transmitter sends next.
    logic [7:0] gen;

    prbs_checker #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .dig_tens  (dig_tens),
        .dig_ones  (dig_ones)
    );

    always #5 clk = ~clk;

    // Generator step in arithmetic form: double modulo 256, then add the
    // parity of the tapped bits (mask 0xB8 = bits 7,5,4,3) as the new LSB.
    function automatic logic [7:0] prbsNext(input logic [7:0] q);
        int v;
        v = (int'(q) * 2) % 256 + ($countones(q & 8'hB8) % 2);
        return 8'(v);
    endfunction

    function automatic logic [7:0] expTens(input int cnt);
`ifdef PRBS_CHK_BCD_EN
        return 8'(cnt / 10);
`else
        return 8'(cnt * 0);
`endif
    endfunction

    function automatic logic [7:0] expOnes(input int cnt);
`ifdef PRBS_CHK_BCD_EN
        return 8'(cnt % 10);
`else
        return 8'(cnt * 0);
`endif
    endfunction

    task automatic modelReset();
        m_locked   = 1'b0;
        m_tracking = 1'b0;
        m_exp      = 8'h00;
        m_match    = 0;
        m_miss     = 0;
        m_cnt      = 0;
        m_pulse    = 1'b0;
    endtask

    // One received byte as seen by the reference model.
    task automatic modelStep(input bit v, input logic [7:0] d, input bit c);
        bit err;
        err = 1'b0;
        if (v) begin
            if (m_locked) begin
                err   = (d != m_exp);
                m_exp = prbsNext(m_exp);
                if (err) begin
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_locked   = 1'b0;
                        m_tracking = 1'b0;
                        m_miss     = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end else if (m_tracking && d == m_exp) begin
                m_exp = prbsNext(m_exp);
                m_match++;
                if (m_match == LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_miss   = 0;
                end
            end else if (d != 8'h00) begin
                m_exp      = prbsNext(d);
                m_match    = 0;
                m_tracking = 1'b1;
            end else begin
                m_tracking = 1'b0;
                m_match    = 0;
            end
        end
        m_pulse = err;
        if (c)
            m_cnt = 0;
        else if (err && m_cnt < 99)
            m_cnt++;
    endtask

    task automatic checkOne(input string tag, input logic [7:0] observed,
                            input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, " locked"},    {7'd0, locked},    {7'd0, m_locked});
        checkOne({tag, " err_pulse"}, {7'd0, err_pulse}, {7'd0, m_pulse});
        checkOne({tag, " err_cnt"},   {1'b0, err_cnt},   8'(m_cnt));
        checkOne({tag, " dig_tens"},  {4'd0, dig_tens},  expTens(m_cnt));
        checkOne({tag, " dig_ones"},  {4'd0, dig_ones},  expOnes(m_cnt));
    endtask

    // Drive one cycle on the falling edge, let the DUT sample it on the
    // rising edge, then compare just after that edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit c,
                                 input string tag);
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        clr        = c;
        @(posedge clk);
        modelStep(v, d, c);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendGood(input string tag);
        applyStimulus(1'b1, gen, 1'b0, tag);
        gen = prbsNext(gen);
    endtask

    task automatic sendBad(input logic [7:0] mask, input string tag);
        applyStimulus(1'b1, gen ^ mask, 1'b0, tag);
        gen = prbsNext(gen);
    endtask

    initial begin
        rst        = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        clr        = 1'b0;
        gen        = 8'h01;
        modelReset();

        // Outputs held at zero during reset.
        #12;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b1;

        // A stream of zero bytes never leaves HUNT.
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 8'h00, 1'b0, "zeros");

        // Lock on 0x01,0x02,0x04,0x08,0x11.
        gen = 8'h01;
        repeat (5) sendGood("lock");
        checkOne("locked after 0x11", {7'd0, locked}, 8'h01);
        checkOne("err_cnt after lock", {1'b0, err_cnt}, 8'h00);

        // 0x23 replaced by 0x24, then 0x47 is still a match.
        sendBad(8'h07, "single err");
        checkOne("single err pulse", {7'd0, err_pulse}, 8'h01);
        checkOne("single err cnt", {1'b0, err_cnt}, 8'h01);
        sendGood("after single err");
        checkOne("flywheel keeps lock", {7'd0, locked}, 8'h01);
        checkOne("flywheel no pulse", {7'd0, err_pulse}, 8'h00);

        // Idle cycles hold everything.
        repeat (3) applyStimulus(1'b0, 8'($urandom), 1'b0, "idle");

        // Clear, then four consecutive errors drop lock; relock after 5.
        applyStimulus(1'b1, gen, 1'b1, "clr good");
        gen = prbsNext(gen);
        repeat (4) sendBad(8'($urandom_range(1, 255)), "loss");
        checkOne("lock lost", {7'd0, locked}, 8'h00);
        checkOne("loss err_cnt", {1'b0, err_cnt}, 8'h04);
        repeat (5) sendGood("relock");
        checkOne("relocked", {7'd0, locked}, 8'h01);
        checkOne("relock err_cnt kept", {1'b0, err_cnt}, 8'h04);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 3)
                applyStimulus(1'b0, 8'($urandom), 1'b0, "rnd idle");
            else if (r < 6)
                sendBad(8'($urandom_range(1, 255)), "rnd bad");
            else if (r == 6) begin
                applyStimulus(1'b1, 8'h00, 1'b0, "rnd zero");
                gen = prbsNext(gen);
            end else if (r == 7) begin
                applyStimulus(1'b1, gen, 1'b1, "rnd clr");
                gen = prbsNext(gen);
            end else if (r == 8)
                gen = 8'($urandom_range(1, 255));
            else
                sendGood("rnd good");
        end

        // Saturation: relock, then alternate bad/good 120 times.
        repeat (10) sendGood("sat relock");
        checkOne("sat locked", {7'd0, locked}, 8'h01);
        for (int i = 0; i < 120; i++) begin
            sendBad(8'($urandom_range(1, 255)), "sat bad");
            sendGood("sat good");
        end
        checkOne("sat err_cnt", {1'b0, err_cnt}, 8'd99);
`ifdef PRBS_CHK_BCD_EN
        checkOne("sat tens", {4'd0, dig_tens}, 8'd9);
        checkOne("sat ones", {4'd0, dig_ones}, 8'd9);
`endif
        applyStimulus(1'b1, gen ^ 8'h5A, 1'b1, "clr with err");
        gen = prbsNext(gen);
        checkOne("clr wins count", {1'b0, err_cnt}, 8'h00);
        checkOne("clr keeps pulse", {7'd0, err_pulse}, 8'h01);

        // Reach err_cnt=5 while locked, then reset between edges.
        for (int i = 0; i < 5; i++) begin
            sendBad(8'($urandom_range(1, 255)), "pre-reset bad");
            sendGood("pre-reset good");
        end
        checkOne("pre-reset cnt", {1'b0, err_cnt}, 8'h05);
        checkOne("pre-reset locked", {7'd0, locked}, 8'h01);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset");
        @(negedge clk);
        rst = 1'b1;

        // First nonzero byte after release reseeds.
        gen = 8'($urandom_range(1, 255));
        repeat (5) sendGood("post-reset");
        checkOne("post-reset locked", {7'd0, locked}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive matching bytes needed to declare lock (range 1..15).
REQ-002 SHALL have parameter LOSS_CNT, default 4: consecutive mismatching bytes in LOCKED that drop lock (range 1..15).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: data_in  input  8  received PRBS byte.
REQ-006 SHALL have port: data_valid  input  1  data_in sampled on an edge where data_valid=1.
REQ-007 SHALL have port: clr  input  1  synchronous clear of the error counter.
REQ-008 SHALL have port: locked  output  1  checker is in LOCKED.
REQ-009 SHALL have port: err_pulse  output  1  one-cycle pulse per mismatched byte while LOCKED.
REQ-010 SHALL have port: err_cnt  output  7  binary error count, saturating at 99.
REQ-011 SHALL have ports: dig_tens, dig_ones  output  4 each  BCD digits of err_cnt, for the 7-segment decoder.

Function
REQ-012 SHALL use the same LFSR as the generator: next(q) = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
REQ-013 SHALL implement three states, HUNT, SYNC and LOCKED, with state and all outputs registered.
REQ-014 HUNT, valid nonzero byte: expected<=next(data_in), match_cnt<=0, go to SYNC; 0x00 is ignored and the block stays in HUNT.
REQ-015 SYNC, valid byte equal to expected: expected<=next(expected), match_cnt+1; when match_cnt reaches LOCK_CNT, go to LOCKED.
REQ-016 SYNC, valid mismatch: reseed from data_in as in HUNT (zero byte -> HUNT), match_cnt<=0; no error counted.
REQ-017 LOCKED, every valid byte: expected<=next(expected) regardless of match (flywheel, no reseed).
REQ-018 LOCKED, mismatch: err_pulse=1 for exactly the cycle after the sampling edge; err_cnt+1 (holds at 99); miss_cnt+1; when miss_cnt reaches LOSS_CNT, go to HUNT and set miss_cnt<=0.
REQ-019 LOCKED, match: miss_cnt<=0.
REQ-020 locked SHALL be 1 exactly while state=LOCKED, updating on the same edge as the state change.
REQ-021 data_valid=0: all state, counters and expected SHALL hold; err_pulse=0.
REQ-022 clr=1: err_cnt<=0 and BCD digits<=0; if an error occurs on the same edge, clr wins for the count but err_pulse still asserts; clr SHALL NOT affect state or lock.
REQ-023 Losing lock SHALL NOT clear err_cnt.

Reset
REQ-024 rst=0 SHALL asynchronously force: state=HUNT, expected=0x00, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_cnt=0, dig_tens=0, dig_ones=0.
REQ-025 Reset asserted mid-stream SHALL abandon lock immediately; after release, the first valid nonzero byte reseeds per REQ-014.

Configuration
REQ-026 Macro PRBS_CHK_BCD_EN defined: dig_tens and dig_ones SHALL be maintained as a BCD counter tracking err_cnt (ones wraps 9->0 with tens increment; both hold at 9/9).
REQ-027 Macro PRBS_CHK_BCD_EN undefined: dig_tens and dig_ones SHALL be tied to 0 and no BCD logic synthesized; err_cnt is unaffected.

Verification
REQ-028 Bytes 0x01,0x02,0x04,0x08,0x11 on consecutive valid cycles (defaults) -> locked=1 the cycle after 0x11 is sampled; err_cnt=0.
REQ-029 While locked, expected next byte 0x23 replaced by 0x24, then 0x47 -> one err_pulse, err_cnt=1, locked stays 1; the 0x47 that follows is accepted as a match.
REQ-030 While locked, 4 consecutive wrong bytes -> err_cnt=4, locked falls after the 4th; a following correct sequence relocks after LOCK_CNT+1 bytes with err_cnt still 4.
REQ-031 Stream of 0x00 bytes from reset -> block stays in HUNT, locked=0, err_cnt=0.
REQ-032 Force 120 errors (relocking as needed) with PRBS_CHK_BCD_EN -> err_cnt=99, dig_tens=9, dig_ones=9; then clr together with an error -> err_cnt=0, err_pulse=1.
REQ-033 rst pulled low while locked with err_cnt=5, between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
